// File: rtl/memory_stage.sv
// Memory stage: issues one data-memory transaction per load/store, waits for
// the ack (bounded by TIMEOUT_CYCLES) and registers the writeback payload.
// Control word layout: [3] MemRead, [2] MemWrite, [1] RegWrite, [0] MemToReg.
module memory_stage #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [3:0]  control_in,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_data,
   input  logic [31:0] memory_data,
   input  logic [4:0]  rd_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        valid_out,
   output logic [3:0]  control_out,
   output logic [31:0] alu_out,
   output logic [31:0] mem_out,
   output logic [4:0]  rd_out,
   output logic        mem_fault
);

   localparam int CTL_MEMREAD  = 3;
   localparam int CTL_MEMWRITE = 2;
   localparam int CTL_REGWRITE = 1;

   // Counter runs 0..TIMEOUT_CYCLES-1; the last value is the final WAIT cycle.
   localparam int              CW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Latched transaction
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;
   logic          we_q, we_d;
   logic [3:0]    ctrl_q, ctrl_d;
   logic [2:0]    f3_q, f3_d;
   logic [4:0]    rd_q, rd_d;

   // Writeback registers
   logic          valid_q, valid_d;
   logic [3:0]    ctl_out_q, ctl_out_d;
   logic [31:0]   alu_q, alu_d;
   logic [31:0]   mem_q, mem_d;
   logic [4:0]    rd_out_q, rd_out_d;
   logic          fault_q, fault_d;

   logic          stall_c;

   // Decode of the incoming op
   logic          is_mem, f3_ok, misal, illegal;
   logic [1:0]    off;
   logic [3:0]    be_n;
   logic [31:0]   wdata_n;

   // Classify the incoming op and pre-format store lanes
   always_comb begin
      off     = alu_data[1:0];
      is_mem  = control_in[CTL_MEMREAD] | control_in[CTL_MEMWRITE];
      f3_ok   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
      misal   = ((funct3[1:0] == 2'b01) && off[0]) ||
                ((funct3[1:0] == 2'b10) && (off != 2'b00));
      illegal = (control_in[CTL_MEMREAD] & control_in[CTL_MEMWRITE]) | ~f3_ok | misal;
      case (funct3[1:0])
         2'b00:   begin be_n = 4'b0001 << off; wdata_n = {4{memory_data[7:0]}};  end
         2'b01:   begin be_n = 4'b0011 << off; wdata_n = {2{memory_data[15:0]}}; end
         default: begin be_n = 4'b1111;        wdata_n = memory_data;            end
      endcase
   end

   // Load lane select and sign/zero extension from the latched access
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;

   always_comb begin
      case (addr_q[1:0])
         2'b00:   ld_byte = dmem_rdata[7:0];
         2'b01:   ld_byte = dmem_rdata[15:8];
         2'b10:   ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_val = {24'h0, ld_byte};
         3'b101:  ld_val = {16'h0, ld_half};
         default: ld_val = dmem_rdata;
      endcase
   end

   // Next-state, latch and writeback selection
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      we_d      = we_q;
      ctrl_d    = ctrl_q;
      f3_d      = f3_q;
      rd_d      = rd_q;
      valid_d   = 1'b0;
      ctl_out_d = ctl_out_q;
      alu_d     = alu_q;
      mem_d     = mem_q;
      rd_out_d  = rd_out_q;
      fault_d   = fault_q;
      stall_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               if (!is_mem || illegal) begin
                  // Pass-through, or fault without touching the bus
                  valid_d   = 1'b1;
                  ctl_out_d = control_in;
                  alu_d     = alu_data;
                  mem_d     = 32'h0;
                  rd_out_d  = rd_in;
                  fault_d   = is_mem;
                  if (is_mem) ctl_out_d[CTL_REGWRITE] = 1'b0;
               end else begin
                  stall_c = 1'b1;
                  state_d = S_WAIT;
                  cnt_d   = '0;
                  addr_d  = alu_data;
                  wdata_d = wdata_n;
                  be_d    = be_n;
                  we_d    = control_in[CTL_MEMWRITE];
                  ctrl_d  = control_in;
                  f3_d    = funct3;
                  rd_d    = rd_in;
               end
            end
         end
         S_WAIT: begin
            if (dmem_ack || (cnt_q == CNT_LAST)) begin
               // Ack wins over a simultaneous timeout; stall drops so the
               // held op upstream is released in the same cycle.
               state_d   = S_IDLE;
               valid_d   = 1'b1;
               ctl_out_d = ctrl_q;
               alu_d     = addr_q;
               rd_out_d  = rd_q;
               fault_d   = ~dmem_ack;
               mem_d     = (dmem_ack && !we_q) ? ld_val : 32'h0;
               if (!dmem_ack) ctl_out_d[CTL_REGWRITE] = 1'b0;
            end else begin
               stall_c = 1'b1;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         be_q      <= 4'h0;
         we_q      <= 1'b0;
         ctrl_q    <= 4'h0;
         f3_q      <= 3'h0;
         rd_q      <= 5'h0;
         valid_q   <= 1'b0;
         ctl_out_q <= 4'h0;
         alu_q     <= 32'h0;
         mem_q     <= 32'h0;
         rd_out_q  <= 5'h0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         we_q      <= we_d;
         ctrl_q    <= ctrl_d;
         f3_q      <= f3_d;
         rd_q      <= rd_d;
         valid_q   <= valid_d;
         ctl_out_q <= ctl_out_d;
         alu_q     <= alu_d;
         mem_q     <= mem_d;
         rd_out_q  <= rd_out_d;
         fault_q   <= fault_d;
      end
   end

   // Bus signals are held from latched values for the whole WAIT period
   assign dmem_req    = (state_q == S_WAIT);
   assign dmem_we     = dmem_req & we_q;
   assign dmem_be     = dmem_req ? be_q : 4'h0;
   assign dmem_addr   = {addr_q[31:2], 2'b00};
   assign dmem_wdata  = wdata_q;
   assign stall_out   = stall_c & ~rst;

   assign valid_out   = valid_q;
   assign control_out = ctl_out_q;
   assign alu_out     = alu_q;
   assign mem_out     = mem_q;
   assign rd_out      = rd_out_q;
   assign mem_fault   = fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomised bench for memory_stage: the bench plays both the execute stage
// (holding the op while stalled) and the data memory, and predicts results
// from load/store semantics.
module tb_memory_stage;
   localparam int TMO = 4;

   logic        clk, rst;
   logic        valid_in;
   logic [3:0]  control_in;
   logic [2:0]  funct3;
   logic [31:0] alu_data, memory_data;
   logic [4:0]  rd_in;
   logic        stall_out, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        valid_out, mem_fault;
   logic [3:0]  control_out;
   logic [31:0] alu_out, mem_out;
   logic [4:0]  rd_out;

   memory_stage #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .control_in(control_in),
      .funct3(funct3), .alu_data(alu_data), .memory_data(memory_data),
      .rd_in(rd_in), .stall_out(stall_out), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .valid_out(valid_out), .control_out(control_out), .alu_out(alu_out),
      .mem_out(mem_out), .rd_out(rd_out), .mem_fault(mem_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [3:0]  ctl;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [4:0]  rd;
      logic        fault;
   } exp_t;

   exp_t        expq[$];
   int          cyc = 0;
   int          n_cmp = 0, n_bad = 0;
   bit          chk_en = 0;
   int          nstall, nreq;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_we;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---- reference model ----
   function automatic void classify(input bit v, input logic [3:0] ctl, input logic [2:0] f3,
                                    input logic [31:0] a, output bit access, output bit fault);
      int sz;
      access = 0; fault = 0;
      if (!v || (!ctl[3] && !ctl[2])) return;
      sz = 1 << f3[1:0];
      if ((ctl[3] && ctl[2]) || !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
          (int'(a[1:0]) % sz) != 0)
         fault = 1;
      else
         access = 1;
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rdat);
      logic [31:0] sh, v;
      sh = rdat >> (8 * int'(a[1:0]));
      case (f3)
         3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;     end
         3'd1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'h10000;   end
         3'd4: v = sh & 32'hFF;
         3'd5: v = sh & 32'hFFFF;
         default: v = rdat;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [31:0] a);
      int n;
      n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 3 : 15;
      return 4'(n << int'(a[1:0]));
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
      if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   // ---- writeback compare: every cycle, valid_out must match the schedule ----
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         if (expq.size() > 0 && expq[0].due == cyc) begin
            exp_t e;
            e = expq.pop_front();
            chk("valid_out", valid_out, 1'b1);
            chk("control_out", control_out, e.ctl);
            chk("alu_out", alu_out, e.alu);
            chk("mem_out", mem_out, e.mem);
            chk("rd_out", rd_out, e.rd);
            chk("mem_fault", mem_fault, e.fault);
         end else begin
            chk("valid_out_idle", valid_out, 1'b0);
         end
      end
   end

   // Drive one op starting just after a rising edge; returns just after the
   // edge that loads its result, with valid_in dropped.
   task automatic run_op(input bit v, input logic [3:0] ctl, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input int ackd, input logic [31:0] rdat);
      bit access, fault, done;
      int w;
      exp_t e;
      classify(v, ctl, f3, a, access, fault);
      nstall = 0; nreq = 0;
      valid_in = v; control_in = ctl; funct3 = f3; alu_data = a;
      memory_data = d; rd_in = rd; dmem_ack = 1'b0; dmem_rdata = $urandom;
      e.ctl = ctl; e.alu = a; e.mem = 32'h0; e.rd = rd; e.fault = fault;
      if (fault) e.ctl[1] = 1'b0;
      @(negedge clk);
      chk("stall_issue", stall_out, access);
      chk("req_issue", dmem_req, 1'b0);
      nstall += int'(stall_out); nreq += int'(dmem_req);
      if (v && !access) begin
         e.due = cyc + 1;
         expq.push_back(e);
      end
      if (access) begin
         w = 0; done = 0;
         while (!done) begin
            @(posedge clk); #1;
            w++;
            dmem_ack = (w == ackd);
            dmem_rdata = (w == ackd) ? rdat : $urandom;
            @(negedge clk);
            done = (w == ackd) || (w == TMO);
            chk("dmem_req", dmem_req, 1'b1);
            chk("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
            chk("dmem_we", dmem_we, ctl[2]);
            if (ctl[2]) begin
               chk("dmem_be", dmem_be, store_be(f3, a));
               chk("dmem_wdata", dmem_wdata, store_data(f3, d));
            end
            chk("stall_wait", stall_out, !done);
            nstall += int'(stall_out); nreq += int'(dmem_req);
            last_addr = dmem_addr; last_be = dmem_be; last_wdata = dmem_wdata; last_we = dmem_we;
            if (done) begin
               if (w == ackd) begin
                  e.fault = 0;
                  e.mem = ctl[2] ? 32'h0 : load_val(f3, a, rdat);
               end else begin
                  e.fault = 1;
                  e.ctl[1] = 1'b0;
               end
               e.due = cyc + 1;
               expq.push_back(e);
            end
         end
      end
      @(posedge clk); #1;
      valid_in = 1'b0; dmem_ack = 1'b0;
   endtask

   // Idle cycles with stray acks that must be ignored
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         valid_in = 1'b0; control_in = 4'($urandom); alu_data = $urandom;
         dmem_ack = 1'($urandom); dmem_rdata = $urandom;
         @(negedge clk);
         chk("idle_req", dmem_req, 1'b0);
         chk("idle_stall", stall_out, 1'b0);
         @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          v;
      logic [3:0]  ctl;
      logic [2:0]  f3;
      logic [31:0] a;
      int          k;

      // ---- reset state (an op is offered but must not stall) ----
      rst = 1'b1; valid_in = 1'b1; control_in = 4'b1011; funct3 = 3'b010;
      alu_data = 32'h100; memory_data = 32'hFFFF_FFFF; rd_in = 5'd7;
      dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      #12;
      chk("rst_valid_out", valid_out, 1'b0);
      chk("rst_mem_fault", mem_fault, 1'b0);
      chk("rst_control_out", control_out, 4'h0);
      chk("rst_alu_out", alu_out, 32'h0);
      chk("rst_mem_out", mem_out, 32'h0);
      chk("rst_rd_out", rd_out, 5'h0);
      chk("rst_dmem_req", dmem_req, 1'b0);
      chk("rst_dmem_we", dmem_we, 1'b0);
      chk("rst_dmem_be", dmem_be, 4'h0);
      chk("rst_dmem_addr", dmem_addr, 32'h0);
      chk("rst_dmem_wdata", dmem_wdata, 32'h0);
      chk("rst_stall", stall_out, 1'b0);
      @(posedge clk); #1;
      valid_in = 1'b0; dmem_ack = 1'b0; rst = 1'b0;
      chk_en = 1;
      idle(2);

      // ADD result passes straight through
      run_op(1, 4'b0010, 3'b000, 32'h0000_0042, 32'h0, 5'd5, 0, 32'h0);
      chk("add_valid", valid_out, 1'b1);
      chk("add_alu", alu_out, 32'h42);
      chk("add_rd", rd_out, 5'd5);
      chk("add_nstall", nstall, 0);

      // LB with ack in the 4th WAIT cycle (coincides with the timeout cycle)
      run_op(1, 4'b1011, 3'b000, 32'h0000_1003, 32'h0, 5'd9, 4, 32'h80FF_0000);
      chk("lb_mem_out", mem_out, 32'hFFFF_FF80);
      chk("lb_fault", mem_fault, 1'b0);
      chk("lb_nstall", nstall, 4);
      chk("lb_addr", last_addr, 32'h0000_1000);

      // SH at offset 2
      run_op(1, 4'b0100, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 5'd0, 1, 32'h0);
      chk("sh_be", last_be, 4'b1100);
      chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
      chk("sh_we", last_we, 1'b1);

      // Misaligned LW faults without touching the bus
      run_op(1, 4'b1011, 3'b010, 32'h0000_3001, 32'h0, 5'd3, 1, 32'h0);
      chk("lw_mis_fault", mem_fault, 1'b1);
      chk("lw_mis_regwrite", control_out[1], 1'b0);
      chk("lw_mis_nreq", nreq, 0);
      chk("lw_mis_nstall", nstall, 0);

      // LW never acked: bus fault after TMO request cycles
      run_op(1, 4'b1011, 3'b010, 32'h0000_5000, 32'h0, 5'd4, 0, 32'h0);
      chk("lw_tmo_nreq", nreq, TMO);
      chk("lw_tmo_fault", mem_fault, 1'b1);
      chk("lw_tmo_regwrite", control_out[1], 1'b0);
      idle(2);

      // Back-to-back zero-wait loads
      run_op(1, 4'b1011, 3'b101, 32'h0000_6002, 32'h0, 5'd1, 1, 32'h1234_8765);
      chk("lhu_mem_out", mem_out, 32'h0000_1234);
      run_op(1, 4'b1011, 3'b001, 32'h0000_6000, 32'h0, 5'd2, 1, 32'h1234_8765);
      chk("lh_mem_out", mem_out, 32'hFFFF_8765);
      idle(1);

      // Reset in the 2nd WAIT cycle, ack arrives afterwards
      valid_in = 1'b1; control_in = 4'b1011; funct3 = 3'b010;
      alu_data = 32'h0000_4000; rd_in = 5'd6; dmem_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("r34_req_before", dmem_req, 1'b1);
      rst = 1'b1; #1;
      chk("r34_req_now", dmem_req, 1'b0);
      chk("r34_stall_now", stall_out, 1'b0);
      chk("r34_valid_now", valid_out, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; valid_in = 1'b0; dmem_ack = 1'b1;
      @(negedge clk);
      chk("r34_req_ack", dmem_req, 1'b0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("r34_valid_after", valid_out, 1'b0);
      @(posedge clk); #1;
      chk("r34_valid_later", valid_out, 1'b0);

      // ---- randomized ops ----
      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 9);
         v = 1;
         case (k)
            0, 1, 2: ctl = {2'b00, 2'($urandom)};
            3, 4, 5: ctl = {2'b10, 2'($urandom)};
            6, 7:    ctl = {2'b01, 2'($urandom)};
            8:       ctl = {2'b11, 2'($urandom)};
            default: begin ctl = 4'($urandom); v = 0; end
         endcase
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
         else begin
            k = $urandom_range(0, 4);
            f3 = (k < 3) ? 3'(k) : 3'(k + 1);
         end
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         run_op(v, ctl, f3, a, $urandom, 5'($urandom), $urandom_range(0, 6), $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(2);
      chk("queue_drained", expq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
